// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the word-selector datapath blocks.
package arb_mux_pkg;

   // Arbitration modes
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Index width needed to address 'value' items (at least one bit)
   function automatic int clog2(input int value);
      int result;
      int rem;
      result = 0;
      rem    = value - 1;
      while (rem > 0) begin
         result = result + 1;
         rem    = rem >> 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Round-robin arbiter: the request vector is duplicated, the lower copy is
// masked to channels above the pointer, and the lowest set bit of the double
// vector wins. Tying the pointer to CHANNELS-1 gives plain fixed priority.
module arb_mux_rr_arbiter
   import arb_mux_pkg::*;
#(
   parameter  int CHANNELS = 16,
   localparam int SEL_W    = clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] i_req,
   input  logic [SEL_W-1:0]    i_ptr,
   output logic [CHANNELS-1:0] o_grant,
   output logic [SEL_W-1:0]    o_idx
);

   localparam logic [SEL_W:0] CH_WIDE = (SEL_W+1)'(CHANNELS);

   logic [CHANNELS-1:0]   w_mask;
   logic [2*CHANNELS-1:0] w_dbl;
   logic [SEL_W:0]        w_pos;
   logic [SEL_W:0]        w_idx_full;
   logic                  w_found;

   // Channels strictly after the pointer get first look in the lower copy
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_mask
         assign w_mask[gi] = (SEL_W'(gi) > i_ptr);
      end
   endgenerate

   assign w_dbl = {i_req, i_req & w_mask};

   // Lowest set bit of the double-width vector is the winner
   always_comb begin
      w_found = 1'b0;
      w_pos   = '0;
      for (int i = 0; i < 2*CHANNELS; i++) begin
         if (!w_found && w_dbl[i]) begin
            w_found = 1'b1;
            w_pos   = (SEL_W+1)'(i);
         end
      end
   end

   // Hits in the upper copy fold back onto the real channel number
   assign w_idx_full = (w_pos >= CH_WIDE) ? (w_pos - CH_WIDE) : w_pos;
   assign o_idx      = SEL_W'(w_idx_full);

   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_grant
         assign o_grant[gi] = w_found && (o_idx == SEL_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/arb_mux.sv
// Arbitrated, registered N-to-1 word selector with valid/ready on both sides.
// Grant comes from the round-robin/fixed arbiter or from a forced index; the
// winning word is captured in a single output register.
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter  int WIDTH       = 16,
   parameter  int CHANNELS    = 16,
   parameter  int ROUND_ROBIN = ARB_RR,
   localparam int SEL_W       = clog2(CHANNELS)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [CHANNELS-1:0]       i_in_valid,
   input  logic [CHANNELS*WIDTH-1:0] i_in_data,
   output logic [CHANNELS-1:0]       o_in_ready,
   input  logic                      i_force_en,
   input  logic [SEL_W-1:0]          i_force_sel,
   output logic                      o_out_valid,
   output logic [WIDTH-1:0]          o_out_data,
   output logic [SEL_W-1:0]          o_out_sel,
   input  logic                      i_out_ready
);

   // Pointer value that makes channel 0 the first candidate
   localparam logic [SEL_W-1:0] PTR_INIT = SEL_W'(CHANNELS - 1);

   logic                r_out_valid;
   logic [WIDTH-1:0]    r_out_data;
   logic [SEL_W-1:0]    r_out_sel;

   logic                w_can_load;
   logic [SEL_W-1:0]    w_ptr;
   logic [CHANNELS-1:0] w_arb_grant;
   logic [SEL_W-1:0]    w_arb_idx;
   logic [CHANNELS-1:0] w_force_oh;
   logic [CHANNELS-1:0] w_grant;
   logic [SEL_W-1:0]    w_gnt_idx;
   logic [WIDTH-1:0]    w_gnt_data;
   logic                w_any;
   logic                w_xfer;

   // Output register is free when empty or being drained this cycle
   assign w_can_load = !r_out_valid || i_out_ready;

   arb_mux_rr_arbiter #(
      .CHANNELS (CHANNELS)
   ) u_arb (
      .i_req   (i_in_valid),
      .i_ptr   (w_ptr),
      .o_grant (w_arb_grant),
      .o_idx   (w_arb_idx)
   );

   // Forced index decoded to one-hot; indices >= CHANNELS decode to nothing
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_force
         assign w_force_oh[gi] = (i_force_sel == SEL_W'(gi));
      end
   endgenerate

   assign w_grant    = i_force_en ? (w_force_oh & i_in_valid) : w_arb_grant;
   assign w_gnt_idx  = i_force_en ? i_force_sel : w_arb_idx;
   assign w_any      = |w_grant;
   assign w_xfer     = w_any && w_can_load;
   assign o_in_ready = w_can_load ? w_grant : '0;

   // AND-OR mux of the granted channel's word
   always_comb begin
      w_gnt_data = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_gnt_data = w_gnt_data | (i_in_data[i*WIDTH +: WIDTH] & {WIDTH{w_grant[i]}});
      end
   end

   // Pointer follows the last accepted channel; fixed priority pins it
   generate
      if (ROUND_ROBIN == ARB_RR) begin : g_rr_ptr
         logic [SEL_W-1:0] r_ptr;

         // Pointer register, moves only on an accepted transfer
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_ptr <= PTR_INIT;
            end else if (w_xfer) begin
               r_ptr <= w_gnt_idx;
            end
         end

         assign w_ptr = r_ptr;
      end else begin : g_fixed_ptr
         assign w_ptr = PTR_INIT;
      end
   endgenerate

   // Output register: load on transfer, otherwise drop valid when popped
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_gnt_data;
         r_out_sel   <= w_gnt_idx;
      end else if (i_out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_out_data  = r_out_data;
   assign o_out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: round-robin, fixed-priority and a small
// non-power-of-two instance, directed tables plus a randomized model check.
module tb_arb_mux;

   localparam int W   = 16;
   localparam int CH  = 16;
   localparam int SW  = 4;
   localparam int W5  = 8;
   localparam int CH5 = 5;
   localparam int SW5 = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // Round-robin instance
   logic [CH-1:0]   rr_valid;
   logic [CH*W-1:0] rr_data;
   logic [CH-1:0]   rr_ready;
   logic            rr_fen;
   logic [SW-1:0]   rr_fsel;
   logic            rr_ov;
   logic [W-1:0]    rr_od;
   logic [SW-1:0]   rr_os;
   logic            rr_ordy;

   // Fixed-priority instance
   logic [CH-1:0]   fp_valid;
   logic [CH*W-1:0] fp_data;
   logic [CH-1:0]   fp_ready;
   logic            fp_fen;
   logic [SW-1:0]   fp_fsel;
   logic            fp_ov;
   logic [W-1:0]    fp_od;
   logic [SW-1:0]   fp_os;
   logic            fp_ordy;

   // Small instance: 5 channels of 8 bits
   logic [CH5-1:0]    sm_valid;
   logic [CH5*W5-1:0] sm_data;
   logic [CH5-1:0]    sm_ready;
   logic              sm_fen;
   logic [SW5-1:0]    sm_fsel;
   logic              sm_ov;
   logic [W5-1:0]     sm_od;
   logic [SW5-1:0]    sm_os;
   logic              sm_ordy;

   arb_mux #(.WIDTH(W), .CHANNELS(CH), .ROUND_ROBIN(1)) u_rr (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(rr_valid), .i_in_data(rr_data),
      .o_in_ready(rr_ready), .i_force_en(rr_fen), .i_force_sel(rr_fsel),
      .o_out_valid(rr_ov), .o_out_data(rr_od), .o_out_sel(rr_os), .i_out_ready(rr_ordy)
   );

   arb_mux #(.WIDTH(W), .CHANNELS(CH), .ROUND_ROBIN(0)) u_fp (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(fp_valid), .i_in_data(fp_data),
      .o_in_ready(fp_ready), .i_force_en(fp_fen), .i_force_sel(fp_fsel),
      .o_out_valid(fp_ov), .o_out_data(fp_od), .o_out_sel(fp_os), .i_out_ready(fp_ordy)
   );

   arb_mux #(.WIDTH(W5), .CHANNELS(CH5), .ROUND_ROBIN(1)) u_sm (
      .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(sm_valid), .i_in_data(sm_data),
      .o_in_ready(sm_ready), .i_force_en(sm_fen), .i_force_sel(sm_fsel),
      .o_out_valid(sm_ov), .o_out_data(sm_od), .o_out_sel(sm_os), .i_out_ready(sm_ordy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rr_word(input int i);
      return 16'h5A00 + 16'(i);
   endfunction

   function automatic logic [W-1:0] fp_word(input int i);
      return 16'hA500 | 16'(i);
   endfunction

   function automatic logic [W5-1:0] sm_word(input int i);
      return 8'h30 + 8'(i);
   endfunction

   // Reference grant: forced index if valid and in range, else first valid
   // channel visited after ptr going round the ring; -1 means no grant.
   function automatic int ref_grant(input logic [CH-1:0] v, input bit fen,
                                    input int fsel, input int ptr);
      if (fen) begin
         if (fsel < CH && v[fsel]) return fsel;
         return -1;
      end
      for (int k = 1; k <= CH; k++) begin
         int c;
         c = (ptr + k) % CH;
         if (v[c]) return c;
      end
      return -1;
   endfunction

   typedef struct packed {
      logic [CH-1:0] valid;
      logic          fen;
      logic [SW-1:0] fsel;
      logic [CH-1:0] exp_ready;
   } fp_vec_t;

   fp_vec_t fp_tab [10];

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit            m_valid;
      logic [W-1:0]  m_data;
      int            m_sel;
      int            m_ptr;
      int            g;
      bit            can;
      logic [CH-1:0] exp_rdy;

      rr_valid = '0; rr_data = '0; rr_fen = 1'b0; rr_fsel = '0; rr_ordy = 1'b0;
      fp_valid = '0; fp_data = '0; fp_fen = 1'b0; fp_fsel = '0; fp_ordy = 1'b0;
      sm_valid = '0; sm_data = '0; sm_fen = 1'b0; sm_fsel = '0; sm_ordy = 1'b0;
      for (int i = 0; i < CH; i++) begin
         rr_data[i*W +: W] = rr_word(i);
         fp_data[i*W +: W] = fp_word(i);
      end
      for (int i = 0; i < CH5; i++) sm_data[i*W5 +: W5] = sm_word(i);

      fp_tab[0] = '{16'h0006, 1'b0, 4'd0, 16'h0002};
      fp_tab[1] = '{16'h0004, 1'b0, 4'd0, 16'h0004};
      fp_tab[2] = '{16'h0000, 1'b0, 4'd0, 16'h0000};
      fp_tab[3] = '{16'h8000, 1'b0, 4'd0, 16'h8000};
      fp_tab[4] = '{16'hFFFF, 1'b0, 4'd0, 16'h0001};
      fp_tab[5] = '{16'h0204, 1'b1, 4'd9, 16'h0200};
      fp_tab[6] = '{16'h0004, 1'b1, 4'd9, 16'h0000};
      fp_tab[7] = '{16'h0204, 1'b1, 4'd2, 16'h0004};
      fp_tab[8] = '{16'hA000, 1'b0, 4'd0, 16'h2000};
      fp_tab[9] = '{16'h0000, 1'b1, 4'd0, 16'h0000};

      // ---- reset state ----
      tick();
      tick();
      chk("rst rr_ov", 32'(rr_ov), 0);
      chk("rst rr_od", 32'(rr_od), 0);
      chk("rst rr_os", 32'(rr_os), 0);
      chk("rst rr_ready", 32'(rr_ready), 0);
      chk("rst fp_ov", 32'(fp_ov), 0);
      chk("rst fp_od", 32'(fp_od), 0);
      chk("rst sm_ov", 32'(sm_ov), 0);
      chk("rst sm_os", 32'(sm_os), 0);
      rst_n = 1'b1;

      // ---- fixed priority table ----
      fp_ordy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         int  exp_sel;
         bit  exp_ov;
         fp_valid = fp_tab[i].valid;
         fp_fen   = fp_tab[i].fen;
         fp_fsel  = fp_tab[i].fsel;
         exp_ov   = (fp_tab[i].exp_ready != '0);
         exp_sel  = 0;
         for (int b = 0; b < CH; b++) if (fp_tab[i].exp_ready[b]) exp_sel = b;
         #1;
         chk($sformatf("fp[%0d] in_ready", i), 32'(fp_ready), 32'(fp_tab[i].exp_ready));
         tick();
         chk($sformatf("fp[%0d] out_valid", i), 32'(fp_ov), 32'(exp_ov));
         if (exp_ov) begin
            chk($sformatf("fp[%0d] out_sel", i), 32'(fp_os), 32'(exp_sel));
            chk($sformatf("fp[%0d] out_data", i), 32'(fp_od), 32'(fp_word(exp_sel)));
         end
         $display("fp vec %0d valid=%h force=%0d/%0d -> sel=%0d ov=%0d", i,
                  fp_tab[i].valid, fp_tab[i].fen, fp_tab[i].fsel, fp_os, fp_ov);
      end
      fp_valid = '0;
      fp_fen   = 1'b0;

      // ---- round-robin fairness: 32 back-to-back words ----
      rr_valid = '1;
      rr_ordy  = 1'b1;
      #1;
      chk("rr first ready", 32'(rr_ready), 32'h0001);
      for (int k = 0; k < 32; k++) begin
         tick();
         chk($sformatf("rr fair[%0d] ov", k), 32'(rr_ov), 1);
         chk($sformatf("rr fair[%0d] sel", k), 32'(rr_os), 32'(k % CH));
         chk($sformatf("rr fair[%0d] data", k), 32'(rr_od), 32'(rr_word(k % CH)));
         $display("rr fair %0d sel=%0d data=%h", k, rr_os, rr_od);
      end

      // ---- backpressure ----
      rr_data[3*W +: W] = 16'hBEEF;
      rr_valid = 16'h0008;
      #1;
      chk("bp load ready", 32'(rr_ready), 32'h0008);
      tick();
      chk("bp load sel", 32'(rr_os), 3);
      chk("bp load data", 32'(rr_od), 32'hBEEF);
      rr_ordy  = 1'b0;
      rr_valid = 16'h0028;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp stall[%0d] ready", k), 32'(rr_ready), 0);
         tick();
         chk($sformatf("bp stall[%0d] ov", k), 32'(rr_ov), 1);
         chk($sformatf("bp stall[%0d] data", k), 32'(rr_od), 32'hBEEF);
         chk($sformatf("bp stall[%0d] sel", k), 32'(rr_os), 3);
         $display("bp stall %0d data=%h sel=%0d", k, rr_od, rr_os);
      end
      rr_ordy = 1'b1;
      #1;
      chk("bp release ready", 32'(rr_ready), 32'h0020);
      tick();
      chk("bp release ov", 32'(rr_ov), 1);
      chk("bp release sel", 32'(rr_os), 5);
      chk("bp release data", 32'(rr_od), 32'(rr_word(5)));
      #1;
      chk("bp next ready", 32'(rr_ready), 32'h0008);
      tick();
      chk("bp next sel", 32'(rr_os), 3);
      rr_data[3*W +: W] = rr_word(3);

      // ---- force mode ----
      rr_fen   = 1'b1;
      rr_fsel  = 4'd9;
      rr_valid = 16'h0204;
      #1;
      chk("force9 ready", 32'(rr_ready), 32'h0200);
      tick();
      chk("force9 sel", 32'(rr_os), 9);
      chk("force9 data", 32'(rr_od), 32'(rr_word(9)));
      rr_valid = 16'h0004;
      #1;
      chk("force9 idle ready", 32'(rr_ready), 0);
      tick();
      chk("force9 idle ov", 32'(rr_ov), 0);
      chk("force9 idle sel held", 32'(rr_os), 9);
      rr_fen = 1'b0;
      #1;
      chk("unforce ready", 32'(rr_ready), 32'h0004);
      tick();
      chk("unforce sel", 32'(rr_os), 2);

      // ---- 5-channel instance: wrap and out-of-range force ----
      sm_valid = 5'h1F;
      sm_ordy  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("sm wrap[%0d] sel", k), 32'(sm_os), 32'(k % CH5));
         chk($sformatf("sm wrap[%0d] data", k), 32'(sm_od), 32'(sm_word(k % CH5)));
         $display("sm wrap %0d sel=%0d data=%h", k, sm_os, sm_od);
      end
      sm_fen  = 1'b1;
      sm_fsel = 3'd7;
      #1;
      chk("sm force7 ready", 32'(sm_ready), 0);
      tick();
      chk("sm force7 ov", 32'(sm_ov), 0);
      sm_fsel = 3'd4;
      #1;
      chk("sm force4 ready", 32'(sm_ready), 32'h10);
      tick();
      chk("sm force4 sel", 32'(sm_os), 4);

      // ---- async reset mid-stream ----
      rr_valid = '1;
      tick();
      chk("ar pre ov", 32'(rr_ov), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar ov immediate", 32'(rr_ov), 0);
      chk("ar od immediate", 32'(rr_od), 0);
      chk("ar os immediate", 32'(rr_os), 0);
      chk("ar sm ov immediate", 32'(sm_ov), 0);
      @(negedge clk);
      rst_n    = 1'b1;
      rr_valid = 16'h0840;
      #1;
      chk("ar first ready", 32'(rr_ready), 32'h0040);
      tick();
      chk("ar first sel", 32'(rr_os), 6);
      $display("async reset: first grant sel=%0d", rr_os);

      // ---- randomized run against the reference model ----
      rst_n = 1'b0;
      tick();
      rst_n   = 1'b1;
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = 0;
      m_ptr   = CH - 1;
      for (int n = 0; n < 400; n++) begin
         rr_valid = 16'($urandom) & 16'($urandom);
         for (int i = 0; i < CH; i++) rr_data[i*W +: W] = 16'($urandom);
         rr_ordy = ($urandom_range(0, 3) != 0);
         rr_fen  = ($urandom_range(0, 7) == 0);
         rr_fsel = 4'($urandom_range(0, CH - 1));
         can     = !m_valid || rr_ordy;
         g       = ref_grant(rr_valid, rr_fen, int'(rr_fsel), m_ptr);
         exp_rdy = '0;
         if (g >= 0 && can) exp_rdy[g] = 1'b1;
         #1;
         chk($sformatf("rnd[%0d] ready", n), 32'(rr_ready), 32'(exp_rdy));
         if (g >= 0 && can) begin
            m_valid = 1'b1;
            m_data  = rr_data[g*W +: W];
            m_sel   = g;
            m_ptr   = g;
            $display("rnd %0d xfer ch=%0d data=%h", n, g, m_data);
         end else if (rr_ordy) begin
            m_valid = 1'b0;
         end
         tick();
         chk($sformatf("rnd[%0d] ov", n), 32'(rr_ov), 32'(m_valid));
         chk($sformatf("rnd[%0d] data", n), 32'(rr_od), 32'(m_data));
         chk($sformatf("rnd[%0d] sel", n), 32'(rr_os), 32'(m_sel));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised, arbitrated, registered successor to the processor's 16-to-1 word selector. Collects up to CHANNELS valid/ready producers (register-file read paths, ALU result, immediate, memory return) and forwards one word per cycle through a single output register with valid/ready flow control. Selection is by fixed priority, round-robin, or forced index, so the legacy direct-select behaviour remains available.

## Interface
- WIDTH, 16: data word width in bits.
- CHANNELS, 16: number of input channels, 2..32.
- ROUND_ROBIN, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- SEL_W, derived as clog2(CHANNELS): index width. Not for override.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  CHANNELS  per-channel request.
- in_data  in  CHANNELS*WIDTH  flattened words; channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  CHANNELS  per-channel accept, one-hot or zero.
- force_en  in  1  bypasses arbitration; only force_sel may be granted.
- force_sel  in  SEL_W  forced channel index.
- out_valid  out  1  output register holds a word.
- out_data  out  WIDTH  registered word.
- out_sel  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer accepts out_data this cycle.

## Operation
- Reset values: out_valid=0, out_data=0, out_sel=0, round-robin pointer=CHANNELS-1, so channel 0 has first priority.
- can_load = !out_valid || out_ready.
- Grant, combinational:
  - force_en=1: grant channel force_sel if in_valid[force_sel] and force_sel<CHANNELS; otherwise no grant.
  - ROUND_ROBIN=1: the first valid channel scanning ptr+1, ptr+2, … with wrap at CHANNELS-1 → 0.
  - ROUND_ROBIN=0: the lowest-index valid channel.
- in_ready[g] = can_load for granted channel g; all other bits 0.
- Transfer occurs on in_valid[g] && in_ready[g]. On the next edge: out_data=in_data[g], out_sel=g, out_valid=1, ptr=g (round-robin only).
- No transfer, but out_ready && out_valid: out_valid→0. out_data and out_sel keep their last values.
- ptr advances only on an accepted transfer, never on a stalled grant. Forced transfers also update ptr.
- A grant is not sticky. A channel may drop in_valid while stalled, and the grant moves the next cycle.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Throughput: 1 word/cycle when out_ready is held high. Simultaneous pop and load in one cycle is legal and yields no bubble.
- Combinational paths: out_ready → in_ready; in_valid/force_* → in_ready. There is no combinational path from any input to out_valid, out_data or out_sel.
- While out_valid && !out_ready, out_data and out_sel are stable and all in_ready are 0.
- Asserting rst_n low mid-transfer discards the held word. Outputs take reset values immediately, not at the next edge.
- If CHANNELS is not a power of two, index values ≥ CHANNELS never appear on out_sel.

## Structure
- Shared package: the mode constants ARB_FIXED=0 and ARB_RR=1, plus a clog2 helper function, also used by the register file and the ALU operand select.
- Sub-module rr_arbiter (CHANNELS): inputs req and ptr; outputs a one-hot grant and the encoded index. Implemented as a double-width request vector with priority masking. The fixed-priority case is the same block with ptr tied to CHANNELS-1.
- Top level: grant/force logic, output register and pointer register.

## Test plan
- Reset and fixed priority: with ROUND_ROBIN=0 and in_valid=16'h0006, out_ready=1 → channel 1 is accepted first and out_sel=1 one cycle later. Channel 2 follows the next cycle after channel 1 drops in_valid. All outputs are 0 during reset.
- Round-robin fairness: in_valid=16'hFFFF held, out_ready=1, 32 cycles → out_sel steps 0,1,…,15,0,… with no repeats and no bubbles.
- Backpressure: out_ready=0 for 5 cycles with channel 3 valid, data 16'hBEEF → out_data stays 16'hBEEF, in_ready=0, ptr unchanged. Releasing out_ready gives a pop and a new load in the same cycle.
- Force mode: force_en=1, force_sel=9, with in_valid on 2 and 9 → only channel 9 is granted, and out_sel=9. With force_sel=9 but in_valid[9]=0 → no grant while channel 2 waits.
- Parameter sweep: WIDTH=8 and CHANNELS=5 with force_sel=7 → no grant. Round-robin wraps from 4 to 0.
- Async reset mid-stream: drop rst_n between edges while out_valid=1 → out_valid=0 immediately. After release, the first grant goes to the lowest valid index.
